px_diff_stream: RTL and testbench

- Streaming, pipelined per-pixel colour-difference engine for packed RGB pixels (R in MSBs, then G, then B).
- Channel widths and blue weighting are parametrised. Three run-time metrics are selectable: weighted L1, max-channel and weighted sum-of-squares.
- Each output is saturated, compared against a threshold, and counted per frame.
- Sits between the frame-buffer reader (current and reference pixel streams) and the motion-detect logic.

---
 rtl/px_diff_stream.sv | 184 ++++++++++++++++++
 tb/tb_px_diff_stream.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/px_diff_stream.sv
// px_diff_stream
// Streaming colour-difference engine for packed {R,G,B} pixel pairs.
// It computes one of three distances between the current and the reference
// pixel:
//   - weighted L1
//   - max-channel
//   - weighted sum of squares
// The distance is saturated to D_W bits and compared against a threshold.
// The over-threshold results are counted per frame.
// The pipeline has two register stages that share one enable. A pair
// accepted in cycle N is presented in cycle N+2.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_px1, in_px2      current / reference pixel {R,G,B}
//   in_last             marks the last pair of a frame
//   mode                0=L1, 1=MAX, 2=SQ, 3=L1
//   thresh              over-threshold limit
//   out_valid/out_ready output handshake
//   out_diff            saturated difference
//   out_over            out_diff > thresh
//   out_last            in_last carried alongside the result
//   frame_count         over-threshold count of the last completed frame
//   frame_done          one-cycle pulse when frame_count updates
module px_diff_stream #(
  parameter int R_W     = 3,
  parameter int G_W     = 3,
  parameter int B_W     = 2,
  parameter int B_SHIFT = 1,
  parameter int D_W     = 8,
  parameter int CNT_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [R_W+G_W+B_W-1:0]   in_px1,
  input  logic [R_W+G_W+B_W-1:0]   in_px2,
  input  logic                     in_last,
  input  logic [1:0]               mode,
  input  logic [D_W-1:0]           thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [D_W-1:0]           out_diff,
  output logic                     out_over,
  output logic                     out_last,
  output logic [CNT_W-1:0]         frame_count,
  output logic                     frame_done
);

  localparam int PX_W  = R_W + G_W + B_W;
  localparam int DB_W  = B_W + B_SHIFT;
  localparam int MX_RG = (R_W > G_W) ? R_W : G_W;
  localparam int MX_W  = (MX_RG > DB_W) ? MX_RG : DB_W;
  // Three squares of MX_W-bit values fit in 2*MX_W+2 bits. The sum is kept at
  // least one bit wider than D_W so that the saturation compare is meaningful.
  localparam int SQ_W  = 2 * MX_W + 2;
  localparam int SUM_W = (SQ_W > D_W) ? SQ_W : D_W + 1;
  localparam logic [SUM_W-1:0] DMAX = {{(SUM_W-D_W){1'b0}}, {D_W{1'b1}}};

  logic en;
  logic xfer;

  logic [R_W-1:0]  r1, r2, dr_c;
  logic [G_W-1:0]  g1, g2, dg_c;
  logic [B_W-1:0]  b1, b2, db_raw;
  logic [DB_W-1:0] db_c;

  logic            s1_valid;
  logic            s1_last;
  logic [R_W-1:0]  s1_dr;
  logic [G_W-1:0]  s1_dg;
  logic [DB_W-1:0] s1_db;
  logic [1:0]      s1_mode;
  logic [D_W-1:0]  s1_thresh;

  logic [SUM_W-1:0] er, eg, eb, l1, mx, sq, raw;
  logic [D_W-1:0]   diff_c;
  logic             over_c;

  logic [CNT_W-1:0] acc, acc_inc;

  // Both stages advance together whenever the output register is empty or
  // is being drained this cycle.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign xfer     = out_valid && out_ready;

  assign r1 = in_px1[PX_W-1 -: R_W];
  assign r2 = in_px2[PX_W-1 -: R_W];
  assign g1 = in_px1[G_W+B_W-1 -: G_W];
  assign g2 = in_px2[G_W+B_W-1 -: G_W];
  assign b1 = in_px1[B_W-1:0];
  assign b2 = in_px2[B_W-1:0];

  assign dr_c   = (r1 >= r2) ? r1 - r2 : r2 - r1;
  assign dg_c   = (g1 >= g2) ? g1 - g2 : g2 - g1;
  assign db_raw = (b1 >= b2) ? b1 - b2 : b2 - b1;
  assign db_c   = DB_W'(db_raw) << B_SHIFT;

  // Stage 1: per-channel absolute differences.
  // mode and thresh are captured here, so later changes only affect new pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_dr     <= '0;
      s1_dg     <= '0;
      s1_db     <= '0;
      s1_mode   <= '0;
      s1_thresh <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s1_dr     <= dr_c;
      s1_dg     <= dg_c;
      s1_db     <= db_c;
      s1_mode   <= mode;
      s1_thresh <= thresh;
    end
  end

  // Metric selection at full precision, followed by saturation and the
  // threshold compare on the saturated value.
  always_comb begin
    er = SUM_W'(s1_dr);
    eg = SUM_W'(s1_dg);
    eb = SUM_W'(s1_db);
    l1 = er + eg + eb;
    mx = er;
    if (eg > mx) mx = eg;
    if (eb > mx) mx = eb;
    sq = er * er + eg * eg + eb * eb;
    case (s1_mode)
      2'd1:    raw = mx;
      2'd2:    raw = sq;
      default: raw = l1;
    endcase
    if (raw > DMAX) diff_c = '1;
    else            diff_c = raw[D_W-1:0];
    over_c = diff_c > s1_thresh;
  end

  // Stage 2: the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_over  <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_diff  <= diff_c;
      out_over  <= over_c;
      out_last  <= s1_last;
    end
  end

  // The count saturates rather than wrapping.
  assign acc_inc = (out_over && (acc != '1)) ? acc + CNT_W'(1) : acc;

  // Per-frame accumulator. The last beat of a frame publishes the count,
  // including that beat's own contribution, and clears the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        if (out_last) begin
          frame_count <= acc_inc;
          frame_done  <= 1'b1;
          acc         <= '0;
        end else begin
          acc <= acc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_px_diff_stream.sv
// tb_px_diff_stream
// Self-checking bench for px_diff_stream.
// The bench uses a narrowed D_W so that the square metric saturates.
// It uses a narrowed CNT_W so that the frame counter saturates.
// Expected results come from an arithmetic model of the colour distance.
// The model is a queue of in-flight results plus a frame counter.
module tb_px_diff_stream;

  localparam int R_W     = 3;
  localparam int G_W     = 3;
  localparam int B_W     = 2;
  localparam int B_SHIFT = 1;
  localparam int D_W     = 6;
  localparam int CNT_W   = 3;
  localparam int PX_W    = R_W + G_W + B_W;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [PX_W-1:0]  in_px1;
  logic [PX_W-1:0]  in_px2;
  logic             in_last;
  logic [1:0]       mode;
  logic [D_W-1:0]   thresh;
  logic             out_valid;
  logic             out_ready;
  logic [D_W-1:0]   out_diff;
  logic             out_over;
  logic             out_last;
  logic [CNT_W-1:0] frame_count;
  logic             frame_done;

  typedef struct {
    int diff;
    bit over;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   nvec = 0;
  int   nmiss = 0;
  int   acc_m = 0;
  int   exp_count = 0;
  bit   exp_done = 0;
  bit   prev_stall = 0;
  int   prev_diff = 0;
  bit   prev_over = 0;
  bit   prev_last = 0;

  px_diff_stream #(
    .R_W(R_W), .G_W(G_W), .B_W(B_W), .B_SHIFT(B_SHIFT), .D_W(D_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_px1(in_px1),
    .in_px2(in_px2),
    .in_last(in_last),
    .mode(mode),
    .thresh(thresh),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_diff(out_diff),
    .out_over(out_over),
    .out_last(out_last),
    .frame_count(frame_count),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Colour distance computed from the channel values with plain integers.
  function automatic int model_diff(input int p1, input int p2, input int m);
    int r1, g1, b1, r2, g2, b2, dr, dg, db, res, sat;
    r1 = (p1 >> (G_W + B_W)) % (1 << R_W);
    r2 = (p2 >> (G_W + B_W)) % (1 << R_W);
    g1 = (p1 >> B_W) % (1 << G_W);
    g2 = (p2 >> B_W) % (1 << G_W);
    b1 = p1 % (1 << B_W);
    b2 = p2 % (1 << B_W);
    dr = (r1 > r2) ? r1 - r2 : r2 - r1;
    dg = (g1 > g2) ? g1 - g2 : g2 - g1;
    db = ((b1 > b2) ? b1 - b2 : b2 - b1) * (1 << B_SHIFT);
    if (m == 1) begin
      res = dr;
      if (dg > res) res = dg;
      if (db > res) res = db;
    end else if (m == 2) begin
      res = dr * dr + dg * dg + db * db;
    end else begin
      res = dr + dg + db;
    end
    sat = (1 << D_W) - 1;
    return (res > sat) ? sat : res;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nmiss++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Runs once per cycle, after the inputs settle and before the rising edge.
  // It checks the handshake, the holding of a stalled result and the frame
  // counter. It then advances the model by whatever transfers this edge makes.
  task automatic checkOutput();
    exp_t e;
    int   d;
    chk("in_ready", in_ready, (!out_valid || out_ready));
    chk("frame_done", frame_done, exp_done);
    chk("frame_count", frame_count, exp_count);
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", out_diff, prev_diff);
      chk("hold_over", out_over, prev_over);
      chk("hold_last", out_last, prev_last);
    end
    exp_done = 0;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_output", out_valid, 0);
      end else begin
        e = expq.pop_front();
        chk("out_diff", out_diff, e.diff);
        chk("out_over", out_over, e.over);
        chk("out_last", out_last, e.last);
        acc_m = acc_m + (e.over ? 1 : 0);
        if (acc_m > CMAX) acc_m = CMAX;
        if (e.last) begin
          exp_count = acc_m;
          exp_done  = 1;
          acc_m     = 0;
        end
      end
    end
    if (in_valid && (!out_valid || out_ready)) begin
      d = model_diff(int'(in_px1), int'(in_px2), int'(mode));
      expq.push_back('{diff: d, over: (d > int'(thresh)), last: in_last});
    end
    prev_stall = out_valid && !out_ready;
    prev_diff  = int'(out_diff);
    prev_over  = out_over;
    prev_last  = out_last;
  endtask

  // Drives one cycle of inputs from a falling edge.
  // Returns at the next falling edge.
  task automatic applyStimulus(input bit v, input int p1, input int p2, input bit last,
                               input int m, input int th, input bit rdy);
    in_valid  = v;
    in_px1    = p1[PX_W-1:0];
    in_px2    = p2[PX_W-1:0];
    in_last   = last;
    mode      = m[1:0];
    thresh    = th[D_W-1:0];
    out_ready = rdy;
    #1;
    checkOutput();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int p1, p2, m, th, cnt;
    bit rdy;
    rst_n = 1'b0; in_valid = 1'b0; in_px1 = '0; in_px2 = '0; in_last = 1'b0;
    mode = '0; thresh = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_diff", out_diff, 0);
    chk("rst_out_over", out_over, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-cycle latency and the strict threshold compare.
    applyStimulus(1, 'hFF, 'h00, 0, 0, 19, 1);
    chk("lat_n1_valid", out_valid, 0);
    applyStimulus(1, 'hFF, 'h00, 1, 0, 20, 1);
    chk("lat_n2_valid", out_valid, 1);
    chk("l1_full_diff", out_diff, 20);
    chk("over_thr19", out_over, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("l1_thr20_diff", out_diff, 20);
    chk("over_thr20", out_over, 0);

    // Each mode at full rate, including the saturation of the square metric.
    applyStimulus(1, 'hA9, 'h5B, 0, 0, 63, 1);
    applyStimulus(1, 'hA9, 'h5B, 0, 1, 63, 1);
    chk("mode_l1", out_diff, 11);
    applyStimulus(1, 'hA9, 'h5B, 0, 2, 63, 1);
    chk("mode_max", out_diff, 4);
    applyStimulus(1, 'hFF, 'h00, 0, 2, 63, 1);
    chk("mode_sq", out_diff, 41);
    applyStimulus(1, 'hFF, 'h00, 1, 0, 63, 1);
    chk("sq_saturated", out_diff, 63);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("l1_unsaturated", out_diff, 20);
    chk("l1_unsat_valid", out_valid, 1);

    // Ten pairs under random backpressure.
    // A pair is held on the inputs until it is accepted.
    cnt = 0;
    p1 = $urandom % 256; p2 = $urandom % 256; m = $urandom % 4; th = $urandom % 64;
    for (int c = 0; c < 100 && cnt < 10; c++) begin
      rdy = ($urandom % 2) == 1;
      if (!out_valid || rdy) begin
        applyStimulus(1, p1, p2, (cnt == 9), m, th, rdy);
        cnt++;
        p1 = $urandom % 256; p2 = $urandom % 256; m = $urandom % 4; th = $urandom % 64;
      end else begin
        applyStimulus(1, p1, p2, (cnt == 9), m, th, rdy);
      end
    end
    chk("stall_all_accepted", cnt, 10);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // A frame with four of its six pairs over the threshold.
    applyStimulus(1, 'hFF, 'h00, 0, 0, 10, 1);
    applyStimulus(1, 'hA9, 'h5B, 0, 0, 10, 1);
    applyStimulus(1, 'h33, 'h33, 0, 0, 10, 1);
    applyStimulus(1, 'hFF, 'h00, 0, 0, 10, 1);
    applyStimulus(1, 'h5B, 'h5B, 0, 0, 10, 1);
    applyStimulus(1, 'hA9, 'h5B, 1, 0, 10, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("frame4_done", frame_done, 1);
    chk("frame4_count", frame_count, 4);
    applyStimulus(1, 'h33, 'h33, 0, 0, 10, 1);
    chk("frame4_done_pulse", frame_done, 0);
    applyStimulus(1, 'hA9, 'hA9, 1, 0, 10, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("frame0_done", frame_done, 1);
    chk("frame0_count", frame_count, 0);

    // Nine over-threshold pairs in one frame saturate the narrowed counter.
    for (int i = 0; i < 9; i++) applyStimulus(1, 'hFF, 'h00, (i == 8), 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("cnt_saturate", frame_count, CMAX);

    // An asynchronous reset in mid-frame drops the in-flight pairs and the
    // partial count.
    for (int i = 0; i < 3; i++) applyStimulus(1, 'hFF, 'h00, 0, 0, 0, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_diff", out_diff, 0);
    chk("arst_out_over", out_over, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_frame_count", frame_count, 0);
    chk("arst_frame_done", frame_done, 0);
    expq.delete();
    acc_m = 0; exp_count = 0; exp_done = 0; prev_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(1, 'hFF, 'h00, (i == 2), 0, 5, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("post_rst_done", frame_done, 1);
    chk("post_rst_count", frame_count, 3);

    // Random traffic: bubbles, backpressure, mode and threshold changes.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 4) != 0, $urandom % 256, $urandom % 256,
                    ($urandom % 6) == 0, $urandom % 4, $urandom % 64,
                    ($urandom % 4) != 0);
    end
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    chk("drain_queue_empty", expq.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
